vc_arbiter_wrr: RTL
===================

VC_ARBITER_WRR -- requirements
Module: vc_arbiter_wrr

Interface
REQ-001 Parameter: DATA_W, 6, word width; bit DATA_W-1 is the destination select.
REQ-002 Parameter: WEIGHT, 4, max consecutive VC0 grants while VC1 eligible; legal range 1..7.
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: reset  in  1  synchronous, active-high reset.
REQ-005 Port: VC0_data  in  DATA_W  head word of VC0 FIFO (first-word-fall-through, valid when !VC0_empty).
REQ-006 Port: VC1_data  in  DATA_W  head word of VC1 FIFO, same rules.
REQ-007 Port: VC0_empty, VC1_empty  in  1 each  FIFO empty flags.
REQ-008 Port: D0_almost_full, D1_almost_full  in  1 each  downstream backpressure; threshold leaves room for one in-flight word.
REQ-009 Port: pop_VC0, pop_VC1  out  1 each  combinational pop; head consumed at the same edge.
REQ-010 Port: data_out  out  DATA_W  registered granted word.
REQ-011 Port: push_D0, push_D1  out  1 each  registered push qualifying data_out.
REQ-012 Port: arb_state  out  2  registered FSM state (IDLE=0, ACTIVE=1, BLOCKED=2).

Function
REQ-013 dest(w) = w[DATA_W-1]; 0 selects D0, 1 selects D1.
REQ-014 elig0 = !VC0_empty && !almost_full(dest(VC0_data)); elig1 likewise for VC1.
REQ-015 Grant: both eligible -> VC1 if wcnt == WEIGHT, else VC0; only one eligible -> that VC; none -> no grant.
REQ-016 At most one of pop_VC0/pop_VC1 high per cycle; pop equals grant; never high while reset is high.
REQ-017 wcnt (3 bits) increments on a VC0 grant while elig1 is high; clears on any VC1 grant or when VC1_empty is high; otherwise holds; never exceeds WEIGHT.
REQ-018 Latency one cycle: word granted in cycle N appears on data_out with exactly one push_Dx high in cycle N+1.
REQ-019 With no grant in cycle N, push_D0 = push_D1 = 0 in N+1; data_out holds its last value.
REQ-020 Head-of-line blocking is per VC: a blocked VC never stalls the other VC.
REQ-021 Next arb_state: IDLE if both FIFOs empty; ACTIVE if a grant issues; BLOCKED if any FIFO non-empty and no grant.
REQ-022 Empty flag and almost_full changing in the same cycle are evaluated combinationally with current values; no extra bubble.
REQ-023 Back-to-back grants sustain one word per cycle when eligible.

Reset
REQ-024 While reset is high at an edge: data_out = 0, push_D0 = push_D1 = 0, wcnt = 0, arb_state = IDLE.
REQ-025 Reset mid-transfer discards the in-flight word; no push occurs in the cycle after reset.
REQ-026 First grant possible in the first cycle with reset low.

Structure
REQ-027 Shared package holds the arb_state encodings, default DATA_W and default WEIGHT.
REQ-028 Weight counter and its clear/increment logic live in sub-module wrr_counter; grant, FSM and output register stay in the top.
REQ-029 All registers in one clock domain; no latches; no combinational path from push outputs back to pop.

Verification
REQ-030 Both VCs hold 10 words to D0, no backpressure, WEIGHT=4 -> grant order VC0 x4, VC1, VC0 x4, VC1 ..., 1 word/cycle.
REQ-031 VC0 head 6'b100101 (D1), D1_almost_full=1, VC1 head 6'b000011 (D0) -> pop_VC1 only; next cycle data_out=6'b000011, push_D0=1, push_D1=0.
REQ-032 Both heads to D0, D0_almost_full=1 for 3 cycles -> no pops, arb_state=BLOCKED; after release, VC0 granted on the first free cycle.
REQ-033 Only VC1 non-empty with 5 words -> 5 consecutive VC1 pops, wcnt stays 0, arb_state ACTIVE then IDLE.
REQ-034 Reset asserted the cycle after a VC0 grant -> push_D0/push_D1 = 0, data_out=0, arb_state=IDLE; traffic resumes correctly after release.
REQ-035 WEIGHT=1, both saturated -> strict alternation VC0, VC1, VC0, VC1.

Source files
------------

// File: rtl/vc_arbiter_wrr_pkg.sv
// Shared definitions for the two-VC weighted round-robin arbiter:
// FSM state encodings, default sizing and the eligibility helper.
package vc_arbiter_wrr_pkg;

  localparam int DEFAULT_DATA_W = 6;
  localparam int DEFAULT_WEIGHT = 4;

  localparam logic [1:0] ARB_IDLE    = 2'd0;
  localparam logic [1:0] ARB_ACTIVE  = 2'd1;
  localparam logic [1:0] ARB_BLOCKED = 2'd2;

  // A VC may be served only if its head exists and its destination can accept a word.
  function automatic logic vc_eligible(input logic empty, input logic dest,
                                       input logic af0, input logic af1);
    return !empty && !(dest ? af1 : af0);
  endfunction

endpackage

// File: rtl/vc_arbiter_wrr_counter.sv
// Weight counter: counts consecutive VC0 grants taken while VC1 was waiting.
// Cleared whenever VC1 is served or has nothing queued.
module wrr_counter
  import vc_arbiter_wrr_pkg::*;
#(
  parameter int WEIGHT = DEFAULT_WEIGHT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       grant0_i,
  input  logic       grant1_i,
  input  logic       elig1_i,
  input  logic       vc1_empty_i,
  output logic [2:0] wcnt_o
);

  logic [2:0] wcnt_q;
  logic [2:0] wcnt_d;

  always_comb begin
    wcnt_d = wcnt_q;
    if (grant1_i || vc1_empty_i) begin
      wcnt_d = 3'd0;
    end else if (grant0_i && elig1_i && (wcnt_q < 3'(WEIGHT))) begin
      wcnt_d = wcnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q <= 3'd0;
    end else begin
      wcnt_q <= wcnt_d;
    end
  end

  assign wcnt_o = wcnt_q;

endmodule

// File: rtl/vc_arbiter_wrr.sv
// Two-VC weighted round-robin arbiter feeding two destinations.
// Pops are combinational; the granted word and its push appear one cycle later.
module vc_arbiter_wrr
  import vc_arbiter_wrr_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int WEIGHT = DEFAULT_WEIGHT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] VC0_data,
  input  logic [DATA_W-1:0] VC1_data,
  input  logic              VC0_empty,
  input  logic              VC1_empty,
  input  logic              D0_almost_full,
  input  logic              D1_almost_full,
  output logic              pop_VC0,
  output logic              pop_VC1,
  output logic [DATA_W-1:0] data_out,
  output logic              push_D0,
  output logic              push_D1,
  output logic [1:0]        arb_state
);

  logic              elig0;
  logic              elig1;
  logic              grant0;
  logic              grant1;
  logic [2:0]        wcnt;
  logic [DATA_W-1:0] data_q, data_d;
  logic              push0_q, push0_d;
  logic              push1_q, push1_d;
  logic [1:0]        state_q, state_d;

  assign elig0 = vc_eligible(VC0_empty, VC0_data[DATA_W-1], D0_almost_full, D1_almost_full);
  assign elig1 = vc_eligible(VC1_empty, VC1_data[DATA_W-1], D0_almost_full, D1_almost_full);

  // VC0 wins ties until it has used its weight while VC1 waited.
  always_comb begin
    grant0 = elig0 && (!elig1 || (wcnt != 3'(WEIGHT))) && !reset;
    grant1 = elig1 && !grant0 && !reset;
  end

  assign pop_VC0 = grant0;
  assign pop_VC1 = grant1;

  wrr_counter #(
    .WEIGHT(WEIGHT)
  ) u_wrr_counter (
    .clk        (clk),
    .reset      (reset),
    .grant0_i   (grant0),
    .grant1_i   (grant1),
    .elig1_i    (elig1),
    .vc1_empty_i(VC1_empty),
    .wcnt_o     (wcnt)
  );

  always_comb begin
    data_d  = data_q;
    push0_d = 1'b0;
    push1_d = 1'b0;
    if (grant0) begin
      data_d  = VC0_data;
      push0_d = !VC0_data[DATA_W-1];
      push1_d = VC0_data[DATA_W-1];
    end else if (grant1) begin
      data_d  = VC1_data;
      push0_d = !VC1_data[DATA_W-1];
      push1_d = VC1_data[DATA_W-1];
    end
  end

  always_comb begin
    if (grant0 || grant1) begin
      state_d = ARB_ACTIVE;
    end else if (VC0_empty && VC1_empty) begin
      state_d = ARB_IDLE;
    end else begin
      state_d = ARB_BLOCKED;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q  <= '0;
      push0_q <= 1'b0;
      push1_q <= 1'b0;
      state_q <= ARB_IDLE;
    end else begin
      data_q  <= data_d;
      push0_q <= push0_d;
      push1_q <= push1_d;
      state_q <= state_d;
    end
  end

  assign data_out  = data_q;
  assign push_D0   = push0_q;
  assign push_D1   = push1_q;
  assign arb_state = state_q;

endmodule
